// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversampling constants and clog2.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  localparam int         OVERSAMPLE = 16;
  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered full/empty/count.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int            AW         = clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop & ~empty_q;
    do_push  = push & (~full_q | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
    full_d  = (count_d == FULL_COUNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/uart_rx_buffered.sv
// 16x oversampled 8N1 UART receiver with majority-vote sampling, feeding a
// FWFT receive FIFO with a valid/ready interface and a sticky overrun flag.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int BAUD_RATE    = 9600,
  parameter int SYS_CLK_FREQ = 120000000,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic [7:0]                  rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [clog2(FIFO_DEPTH):0]  rx_count,
  output logic                        frame_err,
  output logic                        overrun,
  input  logic                        clear_err,
  output logic                        is_receiving
);

  localparam int            TICK_DIV  = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int            TW        = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  rx_state_e     state_q, state_d;
  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          rx_prev_q, rx_prev_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    sub_q, sub_d;
  logic          s_lo_q, s_lo_d;
  logic          s_mid_q, s_mid_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          is_receiving_q, is_receiving_d;

  logic          tick, decide, fall, majority;
  logic          fifo_full, fifo_empty, pop;

  assign tick     = (tick_cnt_q == TICK_LAST);
  assign decide   = tick && (sub_q == SAMPLE_HI);
  assign fall     = rx_prev_q & ~sync2_q;
  assign majority = (s_lo_q & s_mid_q) | (s_lo_q & sync2_q) | (s_mid_q & sync2_q);
  assign pop      = rx_valid & rx_ready;

  always_comb begin
    sync1_d    = rx;
    sync2_d    = sync1_q;
    rx_prev_d  = sync2_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    sub_d      = tick ? sub_q + 4'd1 : sub_q;
    s_lo_d     = (tick && sub_q == SAMPLE_LO)  ? sync2_q : s_lo_q;
    s_mid_d    = (tick && sub_q == SAMPLE_MID) ? sync2_q : s_mid_q;

    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      RX_IDLE: begin
        // Realign the bit grid to the start edge so ticks 7..9 land mid-bit.
        if (fall) begin
          state_d    = RX_START;
          tick_cnt_d = '0;
          sub_d      = '0;
        end
      end
      RX_START: begin
        if (decide) begin
          state_d   = majority ? RX_IDLE : RX_DATA;
          bit_idx_d = '0;
        end
      end
      RX_DATA: begin
        if (decide) begin
          shift_d = {majority, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        if (decide) begin
          if (majority) begin
            push_d  = 1'b1;
            state_d = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (sync2_q) begin
          state_d = RX_IDLE;
        end
      end
      default: state_d = RX_IDLE;
    endcase

    is_receiving_d = (state_d != RX_IDLE);
    overrun_d      = clear_err ? 1'b0
                               : (overrun_q | (push_q & fifo_full & ~pop));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= RX_IDLE;
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      rx_prev_q      <= 1'b1;
      tick_cnt_q     <= '0;
      sub_q          <= '0;
      s_lo_q         <= 1'b1;
      s_mid_q        <= 1'b1;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      push_q         <= 1'b0;
      frame_err_q    <= 1'b0;
      overrun_q      <= 1'b0;
      is_receiving_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      rx_prev_q      <= rx_prev_d;
      tick_cnt_q     <= tick_cnt_d;
      sub_q          <= sub_d;
      s_lo_q         <= s_lo_d;
      s_mid_q        <= s_mid_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      push_q         <= push_d;
      frame_err_q    <= frame_err_d;
      overrun_q      <= overrun_d;
      is_receiving_q <= is_receiving_d;
    end
  end

  // shift_q stays stable until the next frame's first data decision, well after the push.
  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .din   (shift_q),
    .pop   (pop),
    .dout  (rx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (rx_count)
  );

  assign rx_valid     = ~fifo_empty;
  assign frame_err    = frame_err_q;
  assign overrun      = overrun_q;
  assign is_receiving = is_receiving_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboard bench for uart_rx_buffered: stimulus queues expected bytes, a
// negedge monitor pops and compares every accepted FIFO beat.
module tb_uart_rx_buffered;

  localparam int SYS_CLK  = 1600000;
  localparam int BAUD     = 10000;
  localparam int DEPTH    = 8;
  localparam int BIT_CLKS = 160;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [3:0] rx_count;
  logic       frame_err;
  logic       overrun;
  logic       is_receiving;

  int         checks = 0;
  int         failures = 0;
  int         fe_count = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  uart_rx_buffered #(
    .BAUD_RATE    (BAUD),
    .SYS_CLK_FREQ (SYS_CLK),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_count     (rx_count),
    .frame_err    (frame_err),
    .overrun      (overrun),
    .clear_err    (clear_err),
    .is_receiving (is_receiving)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_beat: got 0x%0h expected none", rx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("rx_data", 32'(rx_data), 32'(mon_exp));
      end
    end
    if (rst && frame_err) fe_count++;
  end

  // Sends one 8N1 frame. noise_bit >= 0 flips that data bit around sub-tick 8;
  // ready_on_push raises rx_ready for exactly the cycle the byte is pushed.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                               input int bit_clks, input bit expect_push,
                               input int noise_bit, input bit ready_on_push);
    bit found;
    if (expect_push) exp_q.push_back(data);
    rx = 1'b0;
    wait_clks(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      if (i == noise_bit) begin
        wait_clks(88);
        rx = ~data[i];
        wait_clks(6);
        rx = data[i];
        wait_clks(bit_clks - 94);
      end else begin
        wait_clks(bit_clks);
      end
    end
    rx = stop_bit;
    if (ready_on_push) begin
      found = 1'b0;
      for (int c = 0; c < bit_clks + 40 && !found; c++) begin
        wait_clks(1);
        if (!is_receiving) found = 1'b1;
      end
      checkOutput("push_cycle_seen", 32'(found), 32'd1);
      rx_ready = 1'b1;
      wait_clks(1);
      rx_ready = 1'b0;
      wait_clks(bit_clks);
    end else begin
      wait_clks(bit_clks);
    end
    rx = 1'b1;
    wait_clks(16);
  endtask

  task automatic drain(input string name);
    int c;
    c = 0;
    rx_ready = 1'b1;
    while (rx_valid && c < 100) begin
      wait_clks(1);
      c++;
    end
    rx_ready = 1'b0;
    checkOutput({name, "_drained"}, 32'(rx_valid), 32'd0);
  endtask

  initial begin
    bit found;

    rx  = 1'b1;
    rst = 1'b0;
    wait_clks(4);
    checkOutput("reset_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_count", 32'(rx_count), 32'd0);
    checkOutput("reset_data", 32'(rx_data), 32'h00);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    checkOutput("reset_receiving", 32'(is_receiving), 32'd0);
    rst = 1'b1;
    wait_clks(20);

    // 1: single byte
    rx_ready = 1'b1;
    applyStimulus(8'hA5, 1'b1, BIT_CLKS, 1'b1, -1, 1'b0);
    wait_clks(10);
    checkOutput("t1_delivered", 32'(exp_q.size()), 32'd0);
    checkOutput("t1_count", 32'(rx_count), 32'd0);
    checkOutput("t1_frame_err", 32'(fe_count), 32'd0);

    // 2: start glitch of 40 clocks
    rx = 1'b0;
    wait_clks(40);
    checkOutput("t2_started", 32'(is_receiving), 32'd1);
    rx = 1'b1;
    found = 1'b0;
    for (int c = 0; c < BIT_CLKS && !found; c++) begin
      wait_clks(1);
      if (!is_receiving) found = 1'b1;
    end
    checkOutput("t2_back_idle", 32'(found), 32'd1);
    wait_clks(200);
    checkOutput("t2_count", 32'(rx_count), 32'd0);
    checkOutput("t2_frame_err", 32'(fe_count), 32'd0);

    // 3: framing error then a good byte
    applyStimulus(8'h3C, 1'b0, BIT_CLKS, 1'b0, -1, 1'b0);
    wait_clks(20);
    checkOutput("t3_frame_err", 32'(fe_count), 32'd1);
    checkOutput("t3_empty", 32'(rx_valid), 32'd0);
    checkOutput("t3_idle", 32'(is_receiving), 32'd0);
    applyStimulus(8'h11, 1'b1, BIT_CLKS, 1'b1, -1, 1'b0);
    wait_clks(10);
    checkOutput("t3_delivered", 32'(exp_q.size()), 32'd0);
    checkOutput("t3_frame_err_once", 32'(fe_count), 32'd1);

    // 4: overrun
    rx_ready = 1'b0;
    for (int b = 1; b <= 9; b++) begin
      applyStimulus(8'(b), 1'b1, BIT_CLKS, (b <= 8), -1, 1'b0);
    end
    wait_clks(10);
    checkOutput("t4_count", 32'(rx_count), 32'd8);
    checkOutput("t4_overrun", 32'(overrun), 32'd1);
    checkOutput("t4_head", 32'(rx_data), 32'h01);
    drain("t4");
    checkOutput("t4_all_seen", 32'(exp_q.size()), 32'd0);
    checkOutput("t4_overrun_sticky", 32'(overrun), 32'd1);
    clear_err = 1'b1;
    wait_clks(1);
    clear_err = 1'b0;
    checkOutput("t4_overrun_cleared", 32'(overrun), 32'd0);

    // 5: push into a full FIFO with a same-cycle pop
    for (int b = 1; b <= 8; b++) begin
      applyStimulus(8'(b), 1'b1, BIT_CLKS, 1'b1, -1, 1'b0);
    end
    checkOutput("t5_full_count", 32'(rx_count), 32'd8);
    applyStimulus(8'h09, 1'b1, BIT_CLKS, 1'b1, -1, 1'b1);
    wait_clks(10);
    checkOutput("t5_overrun", 32'(overrun), 32'd0);
    checkOutput("t5_count", 32'(rx_count), 32'd8);
    checkOutput("t5_head", 32'(rx_data), 32'h02);
    drain("t5");
    checkOutput("t5_all_seen", 32'(exp_q.size()), 32'd0);

    // 6: reset during data bit 3
    applyStimulus(8'h77, 1'b1, BIT_CLKS, 1'b1, -1, 1'b0);
    checkOutput("t6_prefill", 32'(rx_count), 32'd1);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rx = (i == 1);
      wait_clks(BIT_CLKS);
    end
    rx = 1'b1;
    wait_clks(80);
    checkOutput("t6_mid_frame", 32'(is_receiving), 32'd1);
    rst = 1'b0;
    wait_clks(1);
    rst = 1'b1;
    exp_q.delete();
    checkOutput("t6_valid", 32'(rx_valid), 32'd0);
    checkOutput("t6_count", 32'(rx_count), 32'd0);
    checkOutput("t6_data", 32'(rx_data), 32'h00);
    checkOutput("t6_receiving", 32'(is_receiving), 32'd0);
    checkOutput("t6_overrun", 32'(overrun), 32'd0);
    checkOutput("t6_frame_err", 32'(frame_err), 32'd0);
    wait_clks(BIT_CLKS);
    rx_ready = 1'b1;
    applyStimulus(8'h5A, 1'b1, BIT_CLKS, 1'b1, -1, 1'b0);
    wait_clks(10);
    checkOutput("t6_delivered", 32'(exp_q.size()), 32'd0);

    // Noise spike on sub-tick 8 of data bit 2 must be outvoted
    applyStimulus(8'hC3, 1'b1, BIT_CLKS, 1'b1, 2, 1'b0);
    // Baud skew of +3% and -3%
    applyStimulus(8'h55, 1'b1, 165, 1'b1, -1, 1'b0);
    applyStimulus(8'h55, 1'b1, 155, 1'b1, -1, 1'b0);
    wait_clks(20);
    checkOutput("final_all_seen", 32'(exp_q.size()), 32'd0);
    checkOutput("final_frame_err", 32'(fe_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
